// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg: shared types and defaults for the instruction-fetch stage.  rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fetch_pkg;

  localparam int          FETCH_PC_W      = 32;
  localparam int          FETCH_INSTR_W   = 32;
  localparam logic [31:0] FETCH_NOP_INSTR = 32'h0000_0000;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } pend_state_e;

  typedef enum logic [1:0] {
    IFID_HOLD   = 2'd0,
    IFID_LOAD   = 2'd1,
    IFID_BUBBLE = 2'd2
  } ifid_sel_e;

  typedef struct packed {
    logic [FETCH_INSTR_W-1:0] instr;
    logic [FETCH_PC_W-1:0]    pc;
    logic                     valid;
  } if_id_t;

endpackage

`default_nettype wire

// File: rtl/fetch_next_pc.sv
// ---------------------------------------------------------------------------
// fetch_next_pc: priority mux for next PC, IF/ID select and pending branch.  rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

import fetch_pkg::*;

module fetch_next_pc #(
  parameter int PC_W = FETCH_PC_W
) (
  input  logic              fetch_en_i,
  input  logic              hazard_pc_write_i,
  input  logic [PC_W-1:0]   hazard_pc_i,
  input  logic              branch_taken_i,
  input  logic [PC_W-1:0]   branch_pc_i,
  input  logic [PC_W-1:0]   pc_q_i,
  input  pend_state_e       pend_q_i,
  input  logic [PC_W-1:0]   pend_target_q_i,
  output logic [PC_W-1:0]   pc_d_o,
  output ifid_sel_e         ifid_sel_o,
  output pend_state_e       pend_d_o,
  output logic [PC_W-1:0]   pend_target_d_o
);

  always_comb begin
    pc_d_o          = pc_q_i;
    ifid_sel_o      = IFID_BUBBLE;
    pend_d_o        = pend_q_i;
    pend_target_d_o = pend_target_q_i;

    if (hazard_pc_write_i) begin
      // A branch colliding with a stall is parked, never dropped.
      pc_d_o     = hazard_pc_i;
      ifid_sel_o = IFID_HOLD;
      if (branch_taken_i) begin
        pend_d_o        = ST_PEND;
        pend_target_d_o = branch_pc_i;
      end
    end else if (branch_taken_i) begin
      pc_d_o   = branch_pc_i;
      pend_d_o = ST_RUN;
    end else if (pend_q_i == ST_PEND) begin
      pc_d_o   = pend_target_q_i;
      pend_d_o = ST_RUN;
    end else if (fetch_en_i) begin
      pc_d_o     = pc_q_i + PC_W'(1);
      ifid_sel_o = IFID_LOAD;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage: PC register, ROM addressing and IF/ID register with stall/branch
// arbitration. Optional perf counters via FETCH_PERF_CNT_EN.  rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

import fetch_pkg::*;

module fetch_stage #(
  parameter int                 PC_W      = FETCH_PC_W,
  parameter int                 INSTR_W   = FETCH_INSTR_W,
  parameter logic [PC_W-1:0]    RESET_PC  = '0,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(FETCH_NOP_INSTR)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               fetch_en,
  input  logic               hazard_pc_write,
  input  logic [PC_W-1:0]    hazard_pc,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_pc,
  output logic [PC_W-1:0]    rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [PC_W-1:0]    if_id_pc,
  output logic               if_id_valid,
  output logic               branch_pending
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_bubble_cnt,
  output logic [31:0]        perf_stall_cnt
`endif
);

  logic [PC_W-1:0]    pc_q, pc_d;
  pend_state_e        pend_q, pend_d;
  logic [PC_W-1:0]    pend_target_q, pend_target_d;
  logic [INSTR_W-1:0] ifid_instr_q;
  logic [PC_W-1:0]    ifid_pc_q;
  logic               ifid_valid_q;
  ifid_sel_e          ifid_sel;

  fetch_next_pc #(.PC_W(PC_W)) u_next_pc (
    .fetch_en_i        (fetch_en),
    .hazard_pc_write_i (hazard_pc_write),
    .hazard_pc_i       (hazard_pc),
    .branch_taken_i    (branch_taken),
    .branch_pc_i       (branch_pc),
    .pc_q_i            (pc_q),
    .pend_q_i          (pend_q),
    .pend_target_q_i   (pend_target_q),
    .pc_d_o            (pc_d),
    .ifid_sel_o        (ifid_sel),
    .pend_d_o          (pend_d),
    .pend_target_d_o   (pend_target_d)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      pend_q        <= ST_RUN;
      pend_target_q <= '0;
      ifid_instr_q  <= NOP_INSTR;
      ifid_pc_q     <= '0;
      ifid_valid_q  <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      pend_q        <= pend_d;
      pend_target_q <= pend_target_d;
      case (ifid_sel)
        IFID_LOAD: begin
          ifid_instr_q <= rom_data;
          ifid_pc_q    <= pc_q;
          ifid_valid_q <= 1'b1;
        end
        IFID_BUBBLE: begin
          // Bubbles keep the last PC so the decode stage sees a stable tag.
          ifid_instr_q <= NOP_INSTR;
          ifid_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign rom_addr       = pc_q;
  assign if_id_instr    = ifid_instr_q;
  assign if_id_pc       = ifid_pc_q;
  assign if_id_valid    = ifid_valid_q;
  assign branch_pending = (pend_q == ST_PEND);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_q, perf_bubble_q, perf_stall_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_fetch_q  <= '0;
      perf_bubble_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if (ifid_sel == IFID_LOAD && perf_fetch_q != 32'hFFFF_FFFF)
        perf_fetch_q <= perf_fetch_q + 32'd1;
      if (ifid_sel == IFID_BUBBLE && perf_bubble_q != 32'hFFFF_FFFF)
        perf_bubble_q <= perf_bubble_q + 32'd1;
      if (ifid_sel == IFID_HOLD && perf_stall_q != 32'hFFFF_FFFF)
        perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetch_cnt  = perf_fetch_q;
  assign perf_bubble_cnt = perf_bubble_q;
  assign perf_stall_cnt  = perf_stall_q;
`endif

endmodule

`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage upstream of ARM_RISC; replaces the ad-hoc PC update logic in the top level.
- Owns the PC register and drives the ROM address. ROM read is combinational.
- Registers the fetched word into the IF/ID pipeline register consumed by the core's decode stage.
- Arbitrates hazard stalls, branch redirects and fetch gating. A branch that collides with a stall is held and applied later, never dropped.

Parameters:
- PC_W, 32, PC and ROM address width (word-addressed, increment by 1)
- INSTR_W, 32, instruction width
- RESET_PC, 0, PC value after reset
- NOP_INSTR, 32'h0000_0000, word driven on if_id_instr for a bubble

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- fetch_en  in  1  1 = fetch normally; 0 = hold PC and emit bubbles
- hazard_pc_write  in  1  stall request from the core's hazard unit
- hazard_pc  in  PC_W  PC to reload while stalled
- branch_taken  in  1  branch redirect from the core (ctrl_branch_out)
- branch_pc  in  PC_W  branch target
- rom_addr  out  PC_W  equals pc_q
- rom_data  in  INSTR_W  combinational ROM output for rom_addr
- if_id_instr  out  INSTR_W  registered instruction to the core
- if_id_pc  out  PC_W  PC of if_id_instr
- if_id_valid  out  1  0 = bubble
- branch_pending  out  1  a deferred branch is held

Behaviour:
- Reset (async, while high):
  - pc_q = RESET_PC
  - if_id_instr = NOP_INSTR, if_id_pc = 0, if_id_valid = 0
  - pend_q = 0, pend_target = 0
- One update per rising clock edge, evaluated in strict priority order:
  1. hazard_pc_write=1:
     - pc_q <= hazard_pc; IF/ID holds its contents.
     - If branch_taken=1 in the same cycle: pend_q <= 1, pend_target <= branch_pc. A later branch overwrites an earlier pending target.
  2. branch_taken=1 (no stall):
     - pc_q <= branch_pc; IF/ID <= bubble; pend_q <= 0.
  3. pend_q=1 (no stall, no branch):
     - pc_q <= pend_target; IF/ID <= bubble; pend_q <= 0.
  4. fetch_en=0:
     - pc_q holds; IF/ID <= bubble. pend_q keeps its value.
  5. Otherwise (normal fetch):
     - IF/ID <= {rom_data, pc_q, valid=1}
     - pc_q <= pc_q + 1, modulo 2^PC_W, so all-ones wraps to 0.
- Bubble = {NOP_INSTR, if_id_pc unchanged, valid=0}.
- Latency: the instruction at address A appears on if_id_instr 1 cycle after pc_q=A, provided no stall, branch or pending redirect occurs in that cycle.
- FSM encoding: the state is pend_q, with two states, RUN and PEND.
  - RUN -> PEND: stall and branch in the same cycle.
  - PEND -> RUN: first non-stall cycle, via rule 2 or rule 3.
  - A stall while in PEND stays in PEND.
- branch_pending = pend_q.
- rom_addr is purely pc_q. There is no combinational path from any input to rom_addr.
- Reset asserted mid-stall or mid-pend discards the pending branch.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds three 32-bit outputs, each reset to 0 and saturating at 32'hFFFF_FFFF:
  - perf_fetch_cnt: counts rule-5 cycles
  - perf_bubble_cnt: counts rules 2, 3 and 4
  - perf_stall_cnt: counts rule 1
- Undefined: these ports and registers are absent; behaviour is otherwise identical.

Decomposition:
- Shared package fetch_pkg holds: PC_W/INSTR_W defaults, NOP_INSTR, the state encoding (ST_RUN=0, ST_PEND=1), and the if_id bundle typedef {instr, pc, valid}.
- One natural sub-module: fetch_next_pc, a combinational priority mux producing next_pc, the IF/ID load/hold/bubble selects and next pend state.
- The registers stay in fetch_stage.

Test Plan:
- Reset then fetch_en=1 with ROM[i]=i+100: rom_addr = 0,1,2,3 on successive cycles; if_id_instr = 100,101,102 with valid=1, lagging by 1 cycle.
- At pc_q=5, assert branch_taken with branch_pc=20 for 1 cycle: next pc_q=20; if_id_valid=0 for that cycle; if_id_instr=120 (if_id_pc=20) the cycle after.
- At pc_q=8, hold hazard_pc_write=1 with hazard_pc=7 for 2 cycles: pc_q=7 both cycles; IF/ID unchanged throughout; normal fetch resumes from 7.
- At pc_q=10, assert stall (hazard_pc=9) and branch_pc=40 together:
  - branch_pending=1 and pc_q=9.
  - Next cycle, with no stall: pc_q=40, bubble, branch_pending=0.
- Set PC_W=4 and RESET_PC=14: pc_q sequence 14,15,0,1.
- fetch_en=0 for 3 cycles at pc_q=3: pc_q stays 3 and if_id_valid=0. Assert reset asynchronously mid-pend: all outputs at reset values immediately, before the next clock edge.
